solenoid_lock_driver: RTL and testbench

- Output-side counterpart of the door reed-sensor input path: converts a one-cycle unlock command into a timed, power-limited drive waveform for a door-lock solenoid.
- Full-on pull-in, then PWM hold until the debounced reed state reports the door open or a timeout expires, then a mandatory cooldown.
- Sits between the control logic (command source) and the solenoid MOSFET gate pin. Consumes the already synchronized and debounced door state (1 = closed, magnet present).

---
 rtl/solenoid_lock_if.sv | 11 +
 rtl/solenoid_lock_driver.sv | 79 +++++++
 tb/tb_solenoid_lock_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/solenoid_lock_if.sv
// solenoid_lock_if: command/door inputs and drive/status outputs of the solenoid lock driver
interface solenoid_lock_if;
  logic       cmd_unlock;
  logic       door_closed;
  logic       sol_out;
  logic       busy;
  logic       fault;
  logic [1:0] state_dbg;
  modport master (output cmd_unlock, door_closed, input sol_out, busy, fault, state_dbg);
  modport slave  (input cmd_unlock, door_closed, output sol_out, busy, fault, state_dbg);
endinterface

// File: rtl/solenoid_lock_driver.sv
// solenoid_lock_driver: timed pull-in, PWM hold and forced cooldown for a door-lock solenoid
module solenoid_lock_driver #(
  parameter int unsigned PULL_CYCLES = 5_000_000,
  parameter int unsigned HOLD_CYCLES = 300_000_000,
  parameter int unsigned COOL_CYCLES = 100_000_000,
  parameter int unsigned PWM_PERIOD  = 100,
  parameter int unsigned PWM_DUTY    = 40,
  parameter int unsigned CNT_W       = 32
) (
  input logic           clk,
  input logic           rst,
  solenoid_lock_if.slave bus
);
  localparam int unsigned PW = $clog2(PWM_PERIOD + 1);
  localparam logic [CNT_W-1:0] PULL_LAST = CNT_W'(PULL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);
  localparam logic [PW-1:0]    PWM_LAST  = PW'(PWM_PERIOD - 1);
  localparam logic [PW:0]      DUTY      = (PW + 1)'(PWM_DUTY);
  typedef enum logic [1:0] {IDLE, PULL, HOLD, COOL} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [PW-1:0]    pwm, pwm_n;
  logic [PW:0]      pwm_inc;
  logic             fault_n, sol_n;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    pwm_n   = '0;
    fault_n = bus.fault;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.cmd_unlock) begin
          state_n = PULL;
          fault_n = 1'b0;
        end
      end
      PULL: if (cnt == PULL_LAST) begin
        state_n = HOLD;
        cnt_n   = '0;
      end
      HOLD: begin
        pwm_n = (pwm == PWM_LAST) ? '0 : pwm + 1'b1;
        // door-open takes priority so a timeout on the same cycle never flags a fault
        if (!bus.door_closed || cnt == HOLD_LAST) begin
          state_n = COOL;
          cnt_n   = '0;
          fault_n = bus.door_closed ? 1'b1 : bus.fault;
        end
      end
      COOL: if (cnt == COOL_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // written as pwm+1 <= duty so a zero duty needs no special case
  assign pwm_inc = {1'b0, pwm_n} + 1'b1;
  assign sol_n   = (state_n == PULL) || (state_n == HOLD && pwm_inc <= DUTY);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pwm         <= '0;
      bus.sol_out <= 1'b0;
      bus.busy    <= 1'b0;
      bus.fault   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pwm         <= pwm_n;
      bus.sol_out <= sol_n;
      bus.busy    <= state_n != IDLE;
      bus.fault   <= fault_n;
    end
  end
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_solenoid_lock_driver.sv
// tb_solenoid_lock_driver: scoreboard bench comparing per-cycle drive/status against expected phase traces
module tb_solenoid_lock_driver;
  typedef struct packed {
    logic [1:0] st;
    logic       sol;
    logic       busy;
    logic       fault;
  } exp_t;
  localparam int PERIOD = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb0[$], sb1[$], sb2[$];
  exp_t obs, e;
  solenoid_lock_if i0 ();
  solenoid_lock_if i1 ();
  solenoid_lock_if i2 ();
  solenoid_lock_driver #(.PULL_CYCLES(10), .HOLD_CYCLES(50), .COOL_CYCLES(20), .PWM_PERIOD(5), .PWM_DUTY(2), .CNT_W(32))
    u0 (.clk(clk), .rst(rst), .bus(i0));
  solenoid_lock_driver #(.PULL_CYCLES(10), .HOLD_CYCLES(50), .COOL_CYCLES(20), .PWM_PERIOD(5), .PWM_DUTY(0), .CNT_W(32))
    u1 (.clk(clk), .rst(rst), .bus(i1));
  solenoid_lock_driver #(.PULL_CYCLES(10), .HOLD_CYCLES(50), .COOL_CYCLES(20), .PWM_PERIOD(5), .PWM_DUTY(5), .CNT_W(32))
    u2 (.clk(clk), .rst(rst), .bus(i2));
  always #5 clk = ~clk;
  function automatic void push_n(int which, logic [1:0] st, int n, int duty, logic f);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.st    = st;
      x.sol   = (st == 2'd1) ? 1'b1 : (st == 2'd2) ? ((i % PERIOD) < duty) : 1'b0;
      x.busy  = st != 2'd0;
      x.fault = f;
      if (which == 0) sb0.push_back(x);
      else if (which == 1) sb1.push_back(x);
      else sb2.push_back(x);
    end
  endfunction
  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("FAIL reset u0: got %b want %b", obs, 5'b0); end
    obs = {i1.state_dbg, i1.sol_out, i1.busy, i1.fault};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("FAIL reset u1: got %b want %b", obs, 5'b0); end
    obs = {i2.state_dbg, i2.sol_out, i2.busy, i2.fault};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("FAIL reset u2: got %b want %b", obs, 5'b0); end
    rst = 1'b0;
    push_n(0, 2'd0, 100, 2, 1'b0);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL idle[%0d]: got %b want %b", k, obs, e); end
    end
  endtask
  task automatic test_timeout();
    int n;
    i0.door_closed = 1'b1;
    i0.cmd_unlock  = 1'b1;
    push_n(0, 2'd1, 10, 2, 1'b0);
    push_n(0, 2'd2, 50, 2, 1'b0);
    push_n(0, 2'd3, 20, 2, 1'b1);
    push_n(0, 2'd0, 5, 2, 1'b1);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i0.cmd_unlock = 1'b0;
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", k, obs, e); end
    end
  endtask
  task automatic test_door_open_hold();
    int n;
    i0.cmd_unlock = 1'b1;
    push_n(0, 2'd1, 10, 2, 1'b0);
    push_n(0, 2'd2, 7, 2, 1'b0);
    push_n(0, 2'd3, 20, 2, 1'b0);
    push_n(0, 2'd0, 3, 2, 1'b0);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i0.cmd_unlock = 1'b0;
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL door_hold[%0d]: got %b want %b", k, obs, e); end
      if (k == 16) i0.door_closed = 1'b0;
    end
  endtask
  task automatic test_door_open_pull();
    int n;
    i0.door_closed = 1'b0;
    i0.cmd_unlock  = 1'b1;
    push_n(0, 2'd1, 10, 2, 1'b0);
    push_n(0, 2'd2, 1, 2, 1'b0);
    push_n(0, 2'd3, 20, 2, 1'b0);
    push_n(0, 2'd0, 3, 2, 1'b0);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i0.cmd_unlock = 1'b0;
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL door_pull[%0d]: got %b want %b", k, obs, e); end
    end
  endtask
  task automatic test_back_to_back();
    int n;
    i0.door_closed = 1'b1;
    i0.cmd_unlock  = 1'b1;
    push_n(0, 2'd1, 10, 2, 1'b0);
    push_n(0, 2'd2, 50, 2, 1'b0);
    push_n(0, 2'd3, 20, 2, 1'b1);
    push_n(0, 2'd0, 1, 2, 1'b1);
    push_n(0, 2'd1, 5, 2, 1'b0);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL retrigger[%0d]: got %b want %b", k, obs, e); end
      i0.cmd_unlock = (k == 3 || k == 30 || k == 70 || k >= 75);
    end
    i0.cmd_unlock = 1'b0;
  endtask
  task automatic test_mid_reset();
    int n;
    rst = 1'b1;
    @(negedge clk);
    obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
    checks++;
    if (obs !== 5'b0) begin errors++; $display("FAIL pre_reset: got %b want %b", obs, 5'b0); end
    rst = 1'b0;
    i0.cmd_unlock = 1'b1;
    push_n(0, 2'd1, 4, 2, 1'b0);
    push_n(0, 2'd0, 6, 2, 1'b0);
    n = sb0.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i0.cmd_unlock = 1'b0;
      obs = {i0.state_dbg, i0.sol_out, i0.busy, i0.fault};
      e = sb0.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL mid_reset[%0d]: got %b want %b", k, obs, e); end
      rst = (k == 3);
    end
  endtask
  task automatic test_duty_bounds();
    int n;
    i1.door_closed = 1'b1;
    i2.door_closed = 1'b1;
    i1.cmd_unlock  = 1'b1;
    i2.cmd_unlock  = 1'b1;
    push_n(1, 2'd1, 10, 0, 1'b0);
    push_n(1, 2'd2, 50, 0, 1'b0);
    push_n(1, 2'd3, 2, 0, 1'b1);
    push_n(2, 2'd1, 10, 5, 1'b0);
    push_n(2, 2'd2, 50, 5, 1'b0);
    push_n(2, 2'd3, 2, 5, 1'b1);
    n = sb1.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i1.cmd_unlock = 1'b0;
      i2.cmd_unlock = 1'b0;
      obs = {i1.state_dbg, i1.sol_out, i1.busy, i1.fault};
      e = sb1.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL duty0[%0d]: got %b want %b", k, obs, e); end
      obs = {i2.state_dbg, i2.sol_out, i2.busy, i2.fault};
      e = sb2.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL duty5[%0d]: got %b want %b", k, obs, e); end
    end
  endtask
  initial begin
    i0.cmd_unlock = 1'b0; i0.door_closed = 1'b1;
    i1.cmd_unlock = 1'b0; i1.door_closed = 1'b1;
    i2.cmd_unlock = 1'b0; i2.door_closed = 1'b1;
    test_reset();
    test_timeout();
    test_door_open_hold();
    test_door_open_pull();
    test_back_to_back();
    test_mid_reset();
    test_duty_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
